uart_frame_tx_arbiter: RTL and testbench
========================================

// Module: uart_frame_tx_arbiter
// PURPOSE
//  Shares one UART frame transmitter (opt/len/data/CRC framer) between N requesters.
//  Round-robin grant; latches the winner's frame; sequences start/busy/done with the framer.
//  Returns per-requester accept/done/error pulses.
//  Sits between command/response sources and the serial TX path, mirroring the RX frame format.
// PARAMETERS
//  N_REQ       4                          number of requesters (>=1)
//  BYTE_SIZE   8                          byte width
//  MAX_MSG_LEN (1<<BYTE_SIZE)-1           maximum frame length
//  DATA_BYTES  $clog2(MAX_MSG_LEN)        payload capacity in bytes (8)
//  DATA_SIZE   DATA_BYTES*BYTE_SIZE       payload width (64)
//  WDOG_CYCLES 4096                       tx_done timeout; only used with UART_TX_ARB_WDOG_EN
//  GNT_W       (N_REQ>1)?$clog2(N_REQ):1  grant index width
// PORTS
//  CLK        in   1                  clock
//  RST        in   1                  synchronous, active-high reset
//  req_valid  in   N_REQ              per-requester frame request; held until req_ready
//  req_opt    in   N_REQ*BYTE_SIZE    flattened opt bytes; slice i = [i*BYTE_SIZE +: BYTE_SIZE]
//  req_len    in   N_REQ*BYTE_SIZE    flattened payload lengths in bytes
//  req_data   in   N_REQ*DATA_SIZE    flattened payloads; first byte in MSBs of the used bytes
//  req_ready  out  N_REQ              one-cycle accept pulse to the winner
//  req_done   out  N_REQ              one-cycle pulse: frame fully sent
//  req_err    out  N_REQ              one-cycle pulse: frame rejected or timed out
//  tx_start   out  1                  one-cycle start to framer
//  tx_opt     out  BYTE_SIZE          latched opt; stable from tx_start until done
//  tx_len     out  BYTE_SIZE          latched length
//  tx_data    out  DATA_SIZE          latched payload
//  tx_busy    in   1                  framer busy; tx_start is never issued while high
//  tx_done    in   1                  framer single-cycle completion pulse
//  o_grant    out  GNT_W              index of the current or last owner
//  o_busy     out  1                  high in every state except ST_IDLE
// BEHAVIOUR
//  Reset: state=ST_IDLE; all outputs 0; tx_* regs 0; last_grant=N_REQ-1, so requester 0 wins first.
//  RST mid-frame aborts immediately. No done or err pulse is issued for the aborted frame.
//  All outputs are registered.
//  FSM:
//   ST_IDLE(0)   if |req_valid: winner w = first set bit searching from last_grant+1, wrapping
//                at N_REQ-1 -> 0. Latch w, opt, len, data. Go to ST_GRANT.
//   ST_GRANT(1)  req_ready[w]=1 for this cycle only.
//                If len==0 or len>DATA_BYTES: go to ST_ERR. Otherwise go to ST_LAUNCH.
//   ST_LAUNCH(2) wait while tx_busy. First cycle tx_busy==0: tx_start=1, go to ST_WAIT.
//   ST_WAIT(3)   on tx_done: go to ST_DONE. tx_done is ignored in every other state.
//   ST_DONE(4)   req_done[w]=1; last_grant<=w; go to ST_IDLE.
//   ST_ERR(5)    req_err[w]=1; last_grant<=w; go to ST_IDLE; no tx_start issued.
//  Timing: req_valid seen in IDLE at cycle t -> req_ready at t+1 -> tx_start at t+2 when framer idle.
//  Minimum gap between frames is 1 IDLE cycle.
//  A requester dropping req_valid before ready is allowed.
//  Requests arriving outside IDLE are only sampled in the next IDLE.
//  Simultaneous requests: round-robin only, no starvation; at most N_REQ-1 frames precede any requester.
//  tx_opt/len/data change only on latch in IDLE.
// CONFIGURATION
//  `define UART_TX_ARB_WDOG_EN
//   Adds a watchdog counter, cleared on entry to ST_WAIT and incremented each ST_WAIT cycle.
//   If the count reaches WDOG_CYCLES without tx_done: go to ST_ERR (req_err[w] pulse).
//   tx_done arriving in the same cycle as expiry takes precedence (goes to ST_DONE).
//  Undefined: no counter; ST_WAIT holds until tx_done or RST.
//   req_err then only comes from length rejection.
// TESTING
//  1 req_valid[0]=1, opt=0x11, len=3, data[23:0]=0xAABBCC, tx_busy=0 at cycle t
//    -> req_ready[0]@t+1, tx_start@t+2 with tx_opt=0x11 tx_len=3; tx_done@t+9 -> req_done[0]@t+10.
//  2 all 4 req_valid held high continuously, tx_done 3 cycles after each tx_start
//    -> grant order 0,1,2,3,0; each req_done exactly once per turn.
//  3 req2 with len=0, then len=9
//    -> req_err[2] pulse each time, no tx_start; o_grant=2; next winner is req3.
//  4 req1 valid with tx_busy held high 5 cycles after GRANT
//    -> tx_start on the first cycle tx_busy=0; tx_data stable throughout.
//  5 WDOG_EN, WDOG_CYCLES=16, tx_done never arrives
//    -> req_err[w] 17 cycles after tx_start, then IDLE.
//    Without the macro, the block stays in ST_WAIT at 100 cycles.
//  6 RST asserted in ST_WAIT
//    -> next cycle all outputs 0 and o_busy=0; later simultaneous req0/req3 -> req0 wins.

Source files
------------

// File: rtl/uart_frame_tx_arbiter.sv
// uart_frame_tx_arbiter
//   Shares one UART frame transmitter (opt/len/data/CRC framer) between N_REQ
//   requesters. A round-robin pick in IDLE latches the winner's frame, then the
//   block hands it to the framer with a tx_start pulse and waits for tx_done.
//   Each requester gets one-cycle accept/done/error pulses.
//
//   Optional feature: define UART_TX_ARB_WDOG_EN to add a tx_done watchdog of
//   WDOG_CYCLES cycles. When it expires the frame ends with a req_err pulse.
//
// Ports
//   CLK, RST   clock, synchronous active-high reset
//   req_valid  per-requester request, held until req_ready
//   req_opt    flattened opt bytes     (slice i = [i*BYTE_SIZE +: BYTE_SIZE])
//   req_len    flattened payload lengths in bytes
//   req_data   flattened payloads      (slice i = [i*DATA_SIZE +: DATA_SIZE])
//   req_ready  one-cycle accept pulse to the winner
//   req_done   one-cycle pulse, frame fully sent
//   req_err    one-cycle pulse, frame rejected (bad length) or timed out
//   tx_start   one-cycle start to the framer
//   tx_opt/tx_len/tx_data  latched frame, stable until the next latch
//   tx_busy    framer busy, tx_start is never raised while it is high
//   tx_done    framer completion pulse
//   o_grant    index of the current or last owner
//   o_busy     high whenever the FSM is not idle
module uart_frame_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int BYTE_SIZE   = 8,
  parameter int MAX_MSG_LEN = (1 << BYTE_SIZE) - 1,
  parameter int DATA_BYTES  = $clog2(MAX_MSG_LEN),
  parameter int DATA_SIZE   = DATA_BYTES * BYTE_SIZE,
  parameter int WDOG_CYCLES = 4096,
  parameter int GNT_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*BYTE_SIZE-1:0]   req_opt,
  input  logic [N_REQ*BYTE_SIZE-1:0]   req_len,
  input  logic [N_REQ*DATA_SIZE-1:0]   req_data,
  output logic [N_REQ-1:0]             req_ready,
  output logic [N_REQ-1:0]             req_done,
  output logic [N_REQ-1:0]             req_err,
  output logic                         tx_start,
  output logic [BYTE_SIZE-1:0]         tx_opt,
  output logic [BYTE_SIZE-1:0]         tx_len,
  output logic [DATA_SIZE-1:0]         tx_data,
  input  logic                         tx_busy,
  input  logic                         tx_done,
  output logic [GNT_W-1:0]             o_grant,
  output logic                         o_busy
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRANT  = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

  localparam logic [BYTE_SIZE-1:0] MAX_LEN = BYTE_SIZE'(DATA_BYTES);

  state_t                 state_q, state_d;
  logic [GNT_W-1:0]       grant_q, grant_d;
  logic [GNT_W-1:0]       last_q, last_d;
  logic [BYTE_SIZE-1:0]   opt_q, opt_d;
  logic [BYTE_SIZE-1:0]   len_q, len_d;
  logic [DATA_SIZE-1:0]   data_q, data_d;
  logic [N_REQ-1:0]       ready_q, ready_d;
  logic [N_REQ-1:0]       done_q, done_d;
  logic [N_REQ-1:0]       err_q, err_d;
  logic                   start_q, start_d;
  logic                   busy_q, busy_d;
  logic                   win_found;
  logic [GNT_W-1:0]       win_idx;
  logic                   len_bad;

`ifdef UART_TX_ARB_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0]      wdog_q, wdog_d;
`endif

  // Round-robin search: first requester after the last owner, wrapping to 0.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_q) + k) % N_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = GNT_W'(idx);
      end else begin
        win_found = win_found;
      end
    end
  end

  assign len_bad = (len_q == '0) || (len_q > MAX_LEN);

  // Next-state logic. Pulse outputs are computed for the state being entered
  // so that, once registered, they are visible during that state.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    opt_d   = opt_q;
    len_d   = len_q;
    data_d  = data_q;
    ready_d = '0;
    done_d  = '0;
    err_d   = '0;
    start_d = 1'b0;
`ifdef UART_TX_ARB_WDOG_EN
    wdog_d  = wdog_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d          = ST_GRANT;
          grant_d          = win_idx;
          opt_d            = req_opt[int'(win_idx)*BYTE_SIZE +: BYTE_SIZE];
          len_d            = req_len[int'(win_idx)*BYTE_SIZE +: BYTE_SIZE];
          data_d           = req_data[int'(win_idx)*DATA_SIZE +: DATA_SIZE];
          ready_d[win_idx] = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (len_bad) begin
          state_d        = ST_ERR;
          err_d[grant_q] = 1'b1;
        end else if (!tx_busy) begin
          // Framer already idle: start now and skip LAUNCH.
          state_d = ST_WAIT;
          start_d = 1'b1;
`ifdef UART_TX_ARB_WDOG_EN
          wdog_d  = '0;
`endif
        end else begin
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (!tx_busy) begin
          state_d = ST_WAIT;
          start_d = 1'b1;
`ifdef UART_TX_ARB_WDOG_EN
          wdog_d  = '0;
`endif
        end else begin
          state_d = ST_LAUNCH;
        end
      end
      ST_WAIT: begin
        // tx_done wins over a watchdog expiry in the same cycle.
        if (tx_done) begin
          state_d         = ST_DONE;
          done_d[grant_q] = 1'b1;
`ifdef UART_TX_ARB_WDOG_EN
        end else if (wdog_q >= WDOG_W'(WDOG_CYCLES)) begin
          state_d        = ST_ERR;
          err_d[grant_q] = 1'b1;
        end else begin
          state_d = ST_WAIT;
          wdog_d  = wdog_q + WDOG_W'(1);
        end
`else
        end else begin
          state_d = ST_WAIT;
        end
`endif
      end
      ST_DONE: begin
        last_d  = grant_q;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        last_d  = grant_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; last owner resets to N_REQ-1 so requester 0 wins first.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= GNT_W'(N_REQ - 1);
      opt_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      ready_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_TX_ARB_WDOG_EN
      wdog_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      opt_q   <= opt_d;
      len_q   <= len_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
      busy_q  <= busy_d;
`ifdef UART_TX_ARB_WDOG_EN
      wdog_q  <= wdog_d;
`endif
    end
  end

  assign req_ready = ready_q;
  assign req_done  = done_q;
  assign req_err   = err_q;
  assign tx_start  = start_q;
  assign tx_opt    = opt_q;
  assign tx_len    = len_q;
  assign tx_data   = data_q;
  assign o_grant   = grant_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_uart_frame_tx_arbiter.sv
// Self-checking bench for uart_frame_tx_arbiter (N_REQ=4, 8-bit bytes,
// 8-byte payload, WDOG_CYCLES=16). A transaction-level model predicts the
// round-robin winner, the accept/start/done/err timing and the latched frame.
module tb_uart_frame_tx_arbiter;

  localparam int N  = 4;
  localparam int B  = 8;
  localparam int DB = 8;
  localparam int DS = 64;

  logic            CLK = 1'b0;
  logic            RST;
  logic [N-1:0]    req_valid;
  logic [N*B-1:0]  req_opt;
  logic [N*B-1:0]  req_len;
  logic [N*DS-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_done;
  logic [N-1:0]    req_err;
  logic            tx_start;
  logic [B-1:0]    tx_opt;
  logic [B-1:0]    tx_len;
  logic [DS-1:0]   tx_data;
  logic            tx_busy;
  logic            tx_done;
  logic [1:0]      o_grant;
  logic            o_busy;

  int total = 0;
  int bad   = 0;
  int last_w;

  always #5 CLK = ~CLK;

  uart_frame_tx_arbiter #(.N_REQ(4), .WDOG_CYCLES(16)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_opt(req_opt), .req_len(req_len), .req_data(req_data),
    .req_ready(req_ready), .req_done(req_done), .req_err(req_err),
    .tx_start(tx_start), .tx_opt(tx_opt), .tx_len(tx_len), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done),
    .o_grant(o_grant), .o_busy(o_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic set_req(input int i, input logic [7:0] o, input logic [7:0] l, input logic [63:0] d);
    req_opt[i*B +: B]   = o;
    req_len[i*B +: B]   = l;
    req_data[i*DS +: DS] = d;
    req_valid[i]        = 1'b1;
  endtask

  // Round-robin reference: first set bit after the last owner, wrapping.
  function automatic int next_w(input logic [N-1:0] m, input int last);
    for (int k = 1; k <= N; k++) begin
      if (m[(last + k) % N]) return (last + k) % N;
    end
    return 0;
  endfunction

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ready"}, req_ready, 64'd0);
    chk({tag, "_done"},  req_done,  64'd0);
    chk({tag, "_err"},   req_err,   64'd0);
    chk({tag, "_start"}, tx_start,  64'd0);
    chk({tag, "_opt"},   tx_opt,    64'd0);
    chk({tag, "_len"},   tx_len,    64'd0);
    chk({tag, "_data"},  tx_data,   64'd0);
    chk({tag, "_grant"}, o_grant,   64'd0);
    chk({tag, "_busy"},  o_busy,    64'd0);
  endtask

  // One frame from request to done/err. mode: 0 drop winner's valid,
  // 1 keep all valids, 2 clear all valids before returning to idle.
  task automatic serve(input int mode, input int busy_cyc, input int done_dly);
    int w;
    int n;
    int starts;
    bit ok;
    logic [7:0]  eo;
    logic [7:0]  el;
    logic [63:0] ed;
    w  = next_w(req_valid, last_w);
    eo = req_opt[w*B +: B];
    el = req_len[w*B +: B];
    ed = req_data[w*DS +: DS];
    ok = (el != 8'd0) && (el <= 8'(DB));
    n  = 0;
    while (!(|req_ready) && n < 30) begin
      tick();
      n++;
    end
    chk("ready", req_ready, 64'd1 << w);
    chk("grant", o_grant, 64'(w));
    chk("obusy", o_busy, 64'd1);
    if (mode == 0) req_valid[w] = 1'b0;
    if (ok) begin
      tx_busy = (busy_cyc > 0);
      repeat (busy_cyc) begin
        tick();
        chk("nostart_busy", tx_start, 64'd0);
      end
      tx_busy = 1'b0;
      tick();
      chk("start", tx_start, 64'd1);
      chk("tx_opt", tx_opt, 64'(eo));
      chk("tx_len", tx_len, 64'(el));
      chk("tx_data", tx_data, ed);
      tx_busy = 1'b1;
      starts  = 0;
      repeat (done_dly) begin
        tick();
        if (tx_start) starts++;
      end
      tx_done = 1'b1;
      tx_busy = 1'b0;
      tick();
      tx_done = 1'b0;
      chk("restart", 64'(starts), 64'd0);
      chk("done", req_done, 64'd1 << w);
      chk("data_hold", tx_data, ed);
    end else begin
      tx_busy = 1'b0;
      tick();
      chk("err", req_err, 64'd1 << w);
      chk("nostart_err", tx_start, 64'd0);
    end
    last_w = w;
    if (mode == 2) req_valid = '0;
    tick();
  endtask

  initial begin
    int n;
    int seen;
    RST = 1'b1; req_valid = '0; req_opt = '0; req_len = '0; req_data = '0;
    tx_busy = 1'b0; tx_done = 1'b0;
    last_w = N - 1;
    repeat (3) tick();
    chk_zero_outputs("reset");
    RST = 1'b0;
    tick();

    // Directed frame with exact cycle timing.
    set_req(0, 8'h11, 8'd3, 64'hAABBCC);
    tick();
    chk("t1_ready", req_ready, 64'h1);
    chk("t1_grant", o_grant, 64'd0);
    req_valid[0] = 1'b0;
    tick();
    chk("t1_start", tx_start, 64'd1);
    chk("t1_opt", tx_opt, 64'h11);
    chk("t1_len", tx_len, 64'd3);
    chk("t1_data", tx_data, 64'hAABBCC);
    tx_busy = 1'b1;
    repeat (7) tick();
    tx_done = 1'b1;
    tx_busy = 1'b0;
    tick();
    tx_done = 1'b0;
    chk("t1_done", req_done, 64'h1);
    last_w = 0;
    tick();

    // All four requesters held continuously: five turns of round-robin.
    for (int i = 0; i < N; i++)
      set_req(i, 8'($urandom), 8'($urandom_range(1, 8)), {$urandom, $urandom});
    for (int t = 0; t < 5; t++) serve((t == 4) ? 2 : 1, 0, 3);

    // Length rejection at both boundaries, then the requester after 2 wins.
    set_req(2, 8'h22, 8'd0, 64'h1234);
    serve(0, 0, 0);
    set_req(2, 8'h23, 8'd9, 64'h5678);
    serve(0, 0, 0);
    chk("t3_grant", o_grant, 64'd2);
    set_req(2, 8'h24, 8'd8, {$urandom, $urandom});
    set_req(3, 8'h33, 8'd1, {$urandom, $urandom});
    serve(0, 0, 2);
    serve(0, 0, 2);

    // Framer busy after grant delays the start.
    set_req(1, 8'h44, 8'd5, {$urandom, $urandom});
    serve(0, 5, 2);

    // Randomized batches including invalid lengths.
    for (int it = 0; it < 12; it++) begin
      logic [N-1:0] m;
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++)
        if (m[i]) set_req(i, 8'($urandom), 8'($urandom_range(0, 10)), {$urandom, $urandom});
      n = 0;
      while ((|req_valid) && n < 8) begin
        serve(0, $urandom_range(0, 3), $urandom_range(0, 4));
        n++;
      end
    end

    // Reset while waiting for tx_done aborts the frame.
    set_req(1, 8'h5A, 8'd2, {$urandom, $urandom});
    n = 0;
    while (!tx_start && n < 10) begin
      tick();
      n++;
      req_valid[1] = 1'b0;
    end
    chk("t6_start", tx_start, 64'd1);
    tx_busy = 1'b1;
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tx_busy = 1'b0;
    chk_zero_outputs("t6_rst");
    last_w = N - 1;
    set_req(0, 8'h01, 8'd4, {$urandom, $urandom});
    set_req(3, 8'h03, 8'd4, {$urandom, $urandom});
    serve(0, 0, 1);
    serve(0, 0, 1);

    // tx_done never arrives.
    set_req(2, 8'h77, 8'd6, {$urandom, $urandom});
    n = 0;
    while (!tx_start && n < 10) begin
      tick();
      n++;
      req_valid[2] = 1'b0;
    end
    chk("t5_start", tx_start, 64'd1);
    tx_busy = 1'b1;
`ifdef UART_TX_ARB_WDOG_EN
    n = 0;
    seen = 0;
    while (!(|req_err) && n < 40) begin
      tick();
      n++;
      if (|req_done) seen++;
    end
    chk("t5_wdog_lat", 64'(n), 64'd17);
    chk("t5_wdog_err", req_err, 64'h4);
    chk("t5_nodone", 64'(seen), 64'd0);
    tick();
    chk("t5_idle", o_busy, 64'd0);
`else
    seen = 0;
    repeat (100) begin
      tick();
      if ((|req_err) || (|req_done)) seen++;
    end
    chk("t5_stuck_busy", o_busy, 64'd1);
    chk("t5_no_pulse", 64'(seen), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
